// File: rtl/rv32_pkg.sv
// Shared RV32I constants and the writeback entry type used by the
// register-file write-side front end.
package rv32_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int RV_XLEN    = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [RV_XLEN-1:0]    data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_load_align.sv
// Load data lane select and sign/zero extension. Purely combinational;
// misaligned offsets are not flagged, the selected lane is used as-is.
module regfile_writeback_load_align
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = data[8*offset +: 8];
  assign half_lane = data[16*offset[1] +: 16];

  always_comb begin
    result = data;
    unique case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   result = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
      F3_LW:   result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Merges load and ALU results onto the single register-file write port,
// buffering ALU results behind loads and tracking in-flight load targets.
module regfile_writeback
  import rv32_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int XLEN           = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_offset,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  sb_set,
  input  logic [REG_ADDR_W-1:0] sb_set_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int PW = $clog2(ALU_FIFO_DEPTH);
  localparam int CW = PW + 1;

  // ---------------- load extension ----------------
  logic [XLEN-1:0] ld_ext;

  regfile_writeback_load_align #(.XLEN(XLEN)) u_align (
    .funct3 (ld_funct3),
    .offset (ld_offset),
    .data   (ld_data),
    .result (ld_ext)
  );

  // ---------------- ALU result FIFO ----------------
  wb_entry_t           fifo [ALU_FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                empty, full, push, pop, bypass;
  logic [ALU_FIFO_DEPTH-1:0] live;

  assign empty     = (count == '0);
  assign full      = (count == CW'(ALU_FIFO_DEPTH));
  assign pop       = !ld_valid && !empty;
  assign bypass    = !ld_valid && empty && alu_valid;
  assign alu_ready = !full || pop;
  assign push      = alu_valid && alu_ready && !bypass;

  function automatic logic [PW-1:0] slot_off(input logic [PW-1:0] idx,
                                             input logic [PW-1:0] base);
    return idx - base;
  endfunction

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    live = '0;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++)
      live[i] = ({1'b0, slot_off(PW'(i), rd_ptr)} < count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr].rd   <= alu_rd;
      fifo[wr_ptr].data <= alu_data;
    end
  end

  // ---------------- port arbitration ----------------
  wb_entry_t sel;
  logic      sel_valid;

  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    if (ld_valid) begin
      sel_valid = 1'b1;
      sel.rd    = ld_rd;
      sel.data  = ld_ext;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel       = fifo[rd_ptr];
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel.rd    = alu_rd;
      sel.data  = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we    <= sel_valid && (sel.rd != '0);
      rf_rd    <= sel.rd;
      rf_wdata <= sel.data;
    end
  end

  // ---------------- load scoreboard ----------------
  logic [31:0] sb, sb_next;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    sb_next = sb;
    if (ld_valid) sb_next[ld_rd]     = 1'b0;
    if (sb_set)   sb_next[sb_set_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= sb_next;
  end

  // ---------------- hazard query ----------------
  always_comb begin
    busy1 = sb[rs1] || (rf_we && (rf_rd == rs1));
    busy2 = sb[rs2] || (rf_we && (rf_rd == rs2));
    for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
      if (live[i] && (fifo[i].rd == rs1)) busy1 = 1'b1;
      if (live[i] && (fifo[i].rd == rs2)) busy2 = 1'b1;
    end
    if (rs1 == '0) busy1 = 1'b0;
    if (rs2 == '0) busy2 = 1'b0;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Write-side front end for the RV32I register file. It merges ALU results and load-unit results onto the register file's single write port (we / rd / wdata), and sign- or zero-extends and lane-aligns load data. It buffers ALU results while a load holds the port, and tracks in-flight load destinations so issue logic can stall on RAW hazards.

Parameters:
ALU_FIFO_DEPTH, 2, ALU result buffer entries (power of 2, >=2)
XLEN, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
ld_valid  in  1  load data returned (always accepted)
ld_rd  in  5  load destination register
ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU)
ld_offset  in  2  byte address bits [1:0]
ld_data  in  XLEN  raw aligned memory word
sb_set  in  1  load issued, mark destination pending
sb_set_rd  in  5  destination of issued load
rs1  in  5  hazard query address 1
rs2  in  5  hazard query address 2
busy1  out  1  rs1 has a pending write
busy2  out  1  rs2 has a pending write
rf_we  out  1  register file write enable
rf_rd  out  5  register file write address
rf_wdata  out  XLEN  register file write data

Behaviour:
- Reset: rf_we=0, rf_rd=0, rf_wdata=0; FIFO empty; scoreboard all clear; alu_ready=1 in the cycle after reset deasserts. Reset mid-operation drops buffered results and pending bits.
- Outputs rf_* are registered. A result selected in cycle N appears on rf_* in cycle N+1 for exactly one cycle.
- Priority per cycle:
  1. ld_valid: load wins the port.
  2. Else FIFO non-empty: pop the head.
  3. Else alu_valid && FIFO empty: bypass straight to the port (1-cycle latency).
- If alu_valid and the ALU result is not taken by the port, it is pushed into the FIFO when not full.
- alu_ready = !full, or (full && pop this cycle).
- A push and a pop in the same cycle are legal. ALU results retire in acceptance order.
- ld_valid has no back-pressure; the load unit never stalls.
- A result with rd==0 is consumed normally, but rf_we stays 0 in its output cycle.
- Load extension, lane = ld_offset:
  - LB (000): sign-extend byte[lane].
  - LBU (100): zero-extend byte[lane].
  - LH (001): sign-extend half[ld_offset[1]].
  - LHU (101): zero-extend half[ld_offset[1]].
  - LW (010): full word.
  - Any other funct3: raw word.
  - Misalignment is not checked.
- Scoreboard (32 bits, bit 0 hardwired 0):
  - sb_set sets bit sb_set_rd.
  - A load writeback clears bit ld_rd.
  - If set and clear hit the same rd in the same cycle, set wins.
- busy1/busy2 are combinational. busyN = 1 if any of:
  - the scoreboard bit for rsN is set;
  - a valid FIFO entry has rd==rsN;
  - the registered rf_we has rf_rd==rsN.
  - Exception: busyN=0 when rsN==0.
- The FIFO uses wrap-around pointers plus a count; full = (count==ALU_FIFO_DEPTH).

Decomposition:
- rv32_pkg:
  - REG_ADDR_W=5.
  - Load funct3 constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU.
  - wb_entry_t struct {rd, data}.
- Sub-module load_align: combinational extend/lane-select, inputs funct3/offset/data, output XLEN.
- FIFO is kept inline.

Test Plan:
1. ALU bypass: FIFO empty, alu_valid with rd=5, data=0x1234 → next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234.
2. Load priority:
   - Stimulus: ld_valid (LB, offset=2, data=0x00800000, rd=7) together with alu_valid (rd=3, data=0xA).
   - Expected, cycle N+1: rd=7, wdata=0xFFFFFF80.
   - Expected, cycle N+2: rd=3, wdata=0xA.
3. FIFO full:
   - Stimulus: ld_valid held 3 cycles while ALU issues 3 results.
   - Expected: alu_ready drops after 2 pushes, and all accepted ALU results retire in order after the loads.
4. Extension matrix on data=0x8001FF7F:
   - LBU offset0 → 0x7F.
   - LB offset1 → 0xFFFFFFFF.
   - LHU offset2 → 0x8001.
   - LH offset2 → 0xFFFF8001.
   - LW → 0x8001FF7F.
5. Scoreboard:
   - sb_set rd=9 → busy1=1 for rs1=9.
   - A load writeback to rd=9 clears it: busy1 stays 1 during the rf_we cycle, then 0.
   - Same-cycle set and clear of rd=9 → bit stays set.
   - Query rs1=0 → busy1=0 always.
6. Edge cases:
   - A write to rd=0 produces no rf_we pulse.
   - rst asserted with 2 FIFO entries and scoreboard bits set → next cycle rf_we=0, no busy bits set, alu_ready=1, and the old entries never appear.
